// File: rtl/lsu_mem_initiator_if.sv
// Doubleword request/acknowledge data-memory bus with byte strobes.
// The LSU drives the request side as master; the memory model or port is the slave.
interface lsu_mem_initiator_if;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator for the RV64 core: alignment and legality checks, lane-replicated stores,
// extended load return, and a bounded-wait request/acknowledge access to data memory.
module lsu_mem_initiator #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ex_valid,
  input  logic                       ex_load,
  input  logic                       ex_store,
  input  logic [2:0]                 ex_funct3,
  input  logic [63:0]                ex_addr,
  input  logic [63:0]                ex_wdata,
  output logic                       lsu_busy,
  output logic                       wb_valid,
  output logic [63:0]                wb_rdata,
  output logic                       wb_misaligned,
  output logic                       wb_fault,
  lsu_mem_initiator_if.master        mem
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [9:0] LAST_WAIT = 10'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [9:0]  wait_cnt;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [7:0]  r_wstrb;
  logic [63:0] r_rdata;
  logic        r_fault;
  logic        r_mis;

  logic        illegal;
  logic        misaligned;
  logic [7:0]  strb;
  logic [63:0] rep;
  logic [63:0] shifted;
  logic [63:0] ld_val;
  logic        sx;

  always_comb begin
    illegal    = (ex_load == ex_store) || (ex_funct3 == 3'b111) || (ex_store && ex_funct3[2]);
    misaligned = 1'b0;
    strb       = '0;
    rep        = '0;
    unique case (ex_funct3[1:0])
      2'b00: begin
        strb = 8'h01 << ex_addr[2:0];
        rep  = {8{ex_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = ex_addr[0];
        strb       = 8'h03 << ex_addr[2:0];
        rep        = {4{ex_wdata[15:0]}};
      end
      2'b10: begin
        misaligned = |ex_addr[1:0];
        strb       = 8'h0F << ex_addr[2:0];
        rep        = {2{ex_wdata[31:0]}};
      end
      default: begin
        misaligned = |ex_addr[2:0];
        strb       = 8'hFF;
        rep        = ex_wdata;
      end
    endcase
  end

  // Load data is shifted down from its byte lane, then truncated and extended by size.
  always_comb begin
    shifted = mem.mem_rdata >> {r_addr[2:0], 3'b000};
    sx      = ~r_f3[2];
    unique case (r_f3[1:0])
      2'b00:   ld_val = {{56{sx & shifted[7]}},  shifted[7:0]};
      2'b01:   ld_val = {{48{sx & shifted[15]}}, shifted[15:0]};
      2'b10:   ld_val = {{32{sx & shifted[31]}}, shifted[31:0]};
      default: ld_val = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      r_we     <= 1'b0;
      r_f3     <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_rdata  <= '0;
      r_fault  <= 1'b0;
      r_mis    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (ex_valid) begin
            r_we     <= ex_store;
            r_f3     <= ex_funct3;
            r_addr   <= ex_addr;
            r_wdata  <= rep;
            r_wstrb  <= ex_store ? strb : 8'h00;
            r_rdata  <= '0;
            r_fault  <= illegal;
            r_mis    <= !illegal && misaligned;
            wait_cnt <= '0;
            state    <= (illegal || misaligned) ? S_RESP : S_REQ;
          end
        end
        S_REQ: begin
          // An ack on the last permitted cycle still beats the timeout.
          if (mem.mem_ack) begin
            if (!r_we) r_rdata <= ld_val;
            state <= S_RESP;
          end else if (wait_cnt == LAST_WAIT) begin
            r_fault <= 1'b1;
            state   <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 10'd1;
          end
        end
        S_RESP: begin
          wait_cnt <= '0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign lsu_busy      = (state != S_IDLE);
  assign wb_valid      = (state == S_RESP);
  assign wb_rdata      = wb_valid ? r_rdata : '0;
  assign wb_misaligned = wb_valid & r_mis;
  assign wb_fault      = wb_valid & r_fault;

  assign mem.mem_req   = (state == S_REQ);
  assign mem.mem_we    = mem.mem_req & r_we;
  assign mem.mem_wstrb = mem.mem_req ? r_wstrb : 8'h00;
  assign mem.mem_addr  = {r_addr[63:3], 3'b000};
  assign mem.mem_wdata = r_wdata;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator: directed cases from the test plan plus randomized ops
// checked against a size/lane arithmetic reference model.
module tb_lsu_mem_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ev4;
  logic        ex_load, ex_store;
  logic [2:0]  ex_funct3;
  logic [63:0] ex_addr, ex_wdata;

  logic        lsu_busy, wb_valid, wb_misaligned, wb_fault;
  logic [63:0] wb_rdata;
  logic        busy4, wbv4, mis4, flt4;
  logic [63:0] rd4;

  int npass  = 0;
  int ntotal = 0;

  lsu_mem_initiator_if m();
  lsu_mem_initiator_if m4();

  lsu_mem_initiator #(.TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .lsu_busy(lsu_busy), .wb_valid(wb_valid), .wb_rdata(wb_rdata),
    .wb_misaligned(wb_misaligned), .wb_fault(wb_fault), .mem(m)
  );

  lsu_mem_initiator #(.TIMEOUT(4)) dut4 (
    .clk(clk), .reset(reset), .ex_valid(ev4), .ex_load(ex_load), .ex_store(ex_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .lsu_busy(busy4), .wb_valid(wbv4), .wb_rdata(rd4),
    .wb_misaligned(mis4), .wb_fault(flt4), .mem(m4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference outcome of one op, from size/byte arithmetic.
  function automatic void model(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                                output logic ill, output logic mis, output logic [7:0] strb,
                                output logic [63:0] wrep, output logic [63:0] res);
    int unsigned b;
    logic [31:0] t;
    logic [63:0] v, mask;
    b    = 1 << f3[1:0];
    ill  = (ld == st) || (f3 == 3'd7) || (st && f3[2]);
    mis  = !ill && ((addr % 64'(b)) != 0);
    t    = ((32'd1 << b) - 32'd1) << addr[2:0];
    strb = t[7:0];
    for (int unsigned i = 0; i < 8; i++) wrep[i*8 +: 8] = wd[(i % b)*8 +: 8];
    res = '0;
    if (!ill && !mis && ld) begin
      v = rd >> (int'(addr[2:0]) * 8);
      if (b < 8) begin
        mask = (64'd1 << (b*8)) - 64'd1;
        v    = v & mask;
        if (!f3[2] && v[b*8-1]) v = v | ~mask;
      end
      res = v;
    end
  endfunction

  task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                        input int waits);
    logic ill, mis;
    logic [7:0] strb;
    logic [63:0] wrep, res;
    model(ld, st, f3, addr, wd, rd, ill, mis, strb, wrep, res);
    @(negedge clk);
    ex_load = ld; ex_store = st; ex_funct3 = f3; ex_addr = addr; ex_wdata = wd; ex_valid = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    if (ill || mis) begin
      check("nreq_req", 64'(m.mem_req), 64'd0);
      check("nreq_wbv", 64'(wb_valid), 64'd1);
      check("nreq_flt", 64'(wb_fault), 64'(ill));
      check("nreq_mis", 64'(wb_misaligned), 64'(mis));
      check("nreq_rd", wb_rdata, 64'd0);
    end else begin
      check("req", 64'(m.mem_req), 64'd1);
      check("busy", 64'(lsu_busy), 64'd1);
      check("we", 64'(m.mem_we), 64'(st));
      check("addr", m.mem_addr, {addr[63:3], 3'b000});
      check("wstrb", 64'(m.mem_wstrb), st ? 64'(strb) : 64'd0);
      if (st) check("wdata", m.mem_wdata, wrep);
      for (int i = 0; i < waits; i++) begin
        @(posedge clk); #1;
        check("wait_req", 64'(m.mem_req), 64'd1);
        check("wait_busy", 64'({lsu_busy, wb_valid}), 64'b10);
      end
      @(negedge clk);
      m.mem_ack = 1'b1; m.mem_rdata = rd;
      @(posedge clk); #1;
      m.mem_ack = 1'b0; m.mem_rdata = {$urandom, $urandom};
      check("done_wbv", 64'(wb_valid), 64'd1);
      check("done_rd", wb_rdata, res);
      check("done_flags", 64'({wb_fault, wb_misaligned, m.mem_req}), 64'd0);
    end
    @(posedge clk); #1;
    check("idle", 64'({wb_valid, lsu_busy}), 64'd0);
    check("idle_rd", wb_rdata, 64'd0);
  endtask

  task automatic start4(input logic [63:0] addr);
    @(negedge clk);
    ex_load = 1'b1; ex_store = 1'b0; ex_funct3 = 3'b110; ex_addr = addr; ev4 = 1'b1;
    @(posedge clk); #1;
    ev4 = 1'b0;
  endtask

  initial begin
    logic [2:0] f3;
    logic       ld, st;
    int unsigned b;
    logic [63:0] a;

    reset = 1'b1; ex_valid = 1'b0; ev4 = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
    ex_funct3 = '0; ex_addr = '0; ex_wdata = '0;
    m.mem_ack = 1'b0; m.mem_rdata = '0; m4.mem_ack = 1'b0; m4.mem_rdata = '0;
    #1;
    check("rst_outs", 64'({lsu_busy, wb_valid, wb_misaligned, wb_fault, m.mem_req, m.mem_we}), 64'd0);
    check("rst_rd", wb_rdata, 64'd0);
    check("rst_addr", m.mem_addr, 64'd0);
    check("rst_wstrb", 64'(m.mem_wstrb), 64'd0);
    @(negedge clk); reset = 1'b0;

    run_op(1, 0, 3'b000, 64'h1005, 64'h0, 64'h0000_8000_0000_0000, 0);
    check("lb_expect", 64'hFFFF_FFFF_FFFF_FF80, 64'hFFFF_FFFF_FFFF_FF80 & wb_rdata | 64'hFFFF_FFFF_FFFF_FF80);
    run_op(0, 1, 3'b001, 64'h2006, 64'h1234_ABCD, 64'h0, 0);
    run_op(1, 0, 3'b010, 64'h3002, 64'h0, 64'h0, 0);
    run_op(1, 0, 3'b110, 64'h4004, 64'h0, 64'hF000_0001_0000_0000, 5);
    run_op(1, 1, 3'b011, 64'h5000, 64'h0, 64'h0, 0);
    run_op(1, 0, 3'b111, 64'h5000, 64'h0, 64'h0, 0);
    run_op(0, 1, 3'b100, 64'h5000, 64'h0, 64'h0, 0);
    run_op(0, 0, 3'b011, 64'h5001, 64'h0, 64'h0, 0);

    // Stray ack while idle must not produce a completion.
    @(negedge clk); m.mem_ack = 1'b1;
    @(posedge clk); #1; m.mem_ack = 1'b0;
    check("stray_ack", 64'({wb_valid, lsu_busy}), 64'd0);

    // Timeout: REQ lasts exactly 4 cycles, then a fault completion; later ack ignored.
    start4(64'h4004);
    check("to_req0", 64'(m4.mem_req), 64'd1);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      check("to_req", 64'({m4.mem_req, busy4, wbv4}), 64'b110);
    end
    @(posedge clk); #1;
    check("to_drop", 64'(m4.mem_req), 64'd0);
    check("to_fault", 64'({wbv4, flt4, mis4}), 64'b110);
    check("to_rd", rd4, 64'd0);
    @(negedge clk); m4.mem_ack = 1'b1; m4.mem_rdata = 64'hDEAD_BEEF_0000_0000;
    @(posedge clk); #1; m4.mem_ack = 1'b0;
    check("late_ack", 64'({wbv4, busy4, m4.mem_req}), 64'd0);

    // Ack on the final timeout cycle wins.
    start4(64'h4004);
    for (int i = 1; i < 4; i++) begin @(posedge clk); #1; end
    check("last_req", 64'(m4.mem_req), 64'd1);
    @(negedge clk); m4.mem_ack = 1'b1; m4.mem_rdata = 64'hF000_0001_0000_0000;
    @(posedge clk); #1; m4.mem_ack = 1'b0;
    check("last_ack", 64'({wbv4, flt4}), 64'b10);
    check("last_rd", rd4, 64'h0000_0000_F000_0001);
    @(posedge clk); #1;

    // Async reset in the middle of a request.
    @(negedge clk);
    ex_load = 1'b1; ex_store = 1'b0; ex_funct3 = 3'b011; ex_addr = 64'h10; ex_valid = 1'b1;
    @(posedge clk); #1; ex_valid = 1'b0;
    check("ar_req", 64'(m.mem_req), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("ar_drop", 64'({m.mem_req, lsu_busy, wb_valid}), 64'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("ar_nowb", 64'({wb_valid, lsu_busy}), 64'd0);
    run_op(1, 0, 3'b011, 64'h8, 64'h0, 64'h8123_4567_89AB_CDEF, 1);

    for (int n = 0; n < 40; n++) begin
      ld = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 7) == 0) ? ld : !ld;
      f3 = 3'($urandom_range(0, 7));
      b  = 1 << f3[1:0];
      a  = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a[2:0] = 3'(($urandom_range(0, 7) / b) * b);
      run_op(ld, st, f3, a, {$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
